// File: rtl/expipe_pkg.sv
// Execution-pipeline payload types shared by the EUs, the CDB mux and the ROB.
package expipe_pkg;

  import len5_pkg::*;

  typedef struct packed {
    logic [ROB_IDX_LEN-1:0]     rob_idx;
    logic [XLEN-1:0]            value;
    logic                       except_raised;
    logic [EXCEPT_CODE_LEN-1:0] except_code;
  } cdb_data_t;

endpackage

// File: rtl/len5_pkg.sv
// Core-wide constants shared by the execution pipeline.
package len5_pkg;

  localparam int unsigned XLEN            = 64;
  localparam int unsigned EU_N            = 6;
  localparam int unsigned ROB_IDX_LEN     = 4;
  localparam int unsigned EXCEPT_CODE_LEN = 5;

endpackage

// File: rtl/cdb_tx_buffer.sv
// Per-EU result FIFO feeding the CDB arbiter. Handshake outputs depend only on
// registered state so the arbiter's combinational grant cannot form a loop.
module cdb_tx_buffer
  import expipe_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       eu_valid_i,
  output logic                       eu_ready_o,
  input  cdb_data_t                  eu_data_i,
  output logic                       cdb_valid_o,
  input  logic                       cdb_ready_i,
  output cdb_data_t                  cdb_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nxt;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic             push;
  logic             pop;
  cdb_data_t        mem_q [DEPTH];

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign push = eu_valid_i & eu_ready_o & ~flush_i;
  assign pop  = cdb_valid_o & cdb_ready_i & ~flush_i;

  always_comb begin
    count_nxt = count_q;
    if (push && !pop) begin
      count_nxt = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_nxt = count_q - CNT_W'(1);
    end
  end

  // Occupancy, pointers and the registered handshake flags.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      eu_ready_o  <= 1'b1;
      cdb_valid_o <= 1'b0;
    end else begin
      count_q     <= count_nxt;
      eu_ready_o  <= (count_nxt < CNT_W'(DEPTH));
      cdb_valid_o <= (count_nxt != '0);
      if (push) tail_q <= wrap_inc(tail_q);
      if (pop)  head_q <= wrap_inc(head_q);
    end
  end

  // Payload storage carries no reset; entries are qualified by count_q.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem_q[tail_q] <= eu_data_i;
    end
  end

  assign cdb_data_o = mem_q[head_q];
  assign count_o    = count_q;

endmodule

// File: tb/tb_cdb_tx_buffer.sv
// Directed self-checking bench for cdb_tx_buffer at DEPTH=4.
module tb_cdb_tx_buffer;

  import len5_pkg::*;
  import expipe_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       flush_i;
  logic       eu_valid_i;
  logic       eu_ready_o;
  cdb_data_t  eu_data_i;
  logic       cdb_valid_o;
  logic       cdb_ready_i;
  cdb_data_t  cdb_data_o;
  logic [2:0] count_o;

  int checks   = 0;
  int failures = 0;

  cdb_tx_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .eu_valid_i  (eu_valid_i),
    .eu_ready_o  (eu_ready_o),
    .eu_data_i   (eu_data_i),
    .cdb_valid_o (cdb_valid_o),
    .cdb_ready_i (cdb_ready_i),
    .cdb_data_o  (cdb_data_o),
    .count_o     (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic cdb_data_t mk(input int idx);
    cdb_data_t d;
    d.rob_idx       = ROB_IDX_LEN'(idx);
    d.value         = 64'h0000_1000 + 64'(idx);
    d.except_raised = 1'b0;
    d.except_code   = '0;
    return d;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  int        exp_idx [5] = '{1, 2, 3, 4, 5};
  int        exp_cnt [5] = '{3, 3, 2, 1, 0};
  logic      acc;
  cdb_data_t held;

  initial begin
    rst_i       = 1'b1;
    flush_i     = 1'b0;
    eu_valid_i  = 1'b0;
    cdb_ready_i = 1'b0;
    eu_data_i   = mk(0);
    step();
    step();
    rst_i = 1'b0;
    check_eq("rst_eu_ready", 64'(eu_ready_o), 64'd1);
    check_eq("rst_cdb_valid", 64'(cdb_valid_o), 64'd0);
    check_eq("rst_count", 64'(count_o), 64'd0);

    // Single result: one-cycle latency, then popped.
    eu_data_i   = mk(3);
    eu_data_i.value = 64'hDEAD;
    eu_valid_i  = 1'b1;
    cdb_ready_i = 1'b1;
    step();
    eu_valid_i = 1'b0;
    check_eq("single_valid", 64'(cdb_valid_o), 64'd1);
    check_eq("single_idx", 64'(cdb_data_o.rob_idx), 64'd3);
    check_eq("single_value", cdb_data_o.value, 64'hDEAD);
    check_eq("single_count1", 64'(count_o), 64'd1);
    step();
    check_eq("single_count0", 64'(count_o), 64'd0);
    check_eq("single_valid0", 64'(cdb_valid_o), 64'd0);

    // Fill with stall: five offered, four accepted.
    cdb_ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      eu_valid_i = 1'b1;
      eu_data_i  = mk(i);
      acc = eu_ready_o;
      check_eq($sformatf("fill_accept_%0d", i), 64'(acc), (i <= 4) ? 64'd1 : 64'd0);
      if (i < 5) step();
    end
    check_eq("fill_count", 64'(count_o), 64'd4);
    check_eq("fill_ready", 64'(eu_ready_o), 64'd0);

    // Drain in order while the EU keeps offering idx 5.
    cdb_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("drain_valid_%0d", k), 64'(cdb_valid_o), 64'd1);
      check_eq($sformatf("drain_idx_%0d", k), 64'(cdb_data_o.rob_idx), 64'(exp_idx[k]));
      acc = eu_valid_i & eu_ready_o;
      if (k == 1) check_eq("drain_push5", 64'(acc), 64'd1);
      step();
      if (acc) eu_valid_i = 1'b0;
      check_eq($sformatf("drain_count_%0d", k), 64'(count_o), 64'(exp_cnt[k]));
    end
    check_eq("drain_empty", 64'(cdb_valid_o), 64'd0);

    // Simultaneous push/pop at count 2, wrapping the pointers.
    cdb_ready_i = 1'b0;
    eu_valid_i  = 1'b1;
    eu_data_i   = mk(6);
    step();
    eu_data_i   = mk(7);
    step();
    check_eq("pp_start_count", 64'(count_o), 64'd2);
    cdb_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      eu_data_i = mk(8 + k);
      check_eq($sformatf("pp_idx_%0d", k), 64'(cdb_data_o.rob_idx), 64'(6 + k));
      check_eq($sformatf("pp_value_%0d", k), cdb_data_o.value, 64'h1000 + 64'(6 + k));
      step();
      check_eq($sformatf("pp_count_%0d", k), 64'(count_o), 64'd2);
    end
    check_eq("pp_head_after", 64'(cdb_data_o.rob_idx), 64'd12);

    // Flush overrides a same-cycle push and pop.
    cdb_ready_i = 1'b0;
    eu_data_i   = mk(14);
    step();
    check_eq("flush_pre_count", 64'(count_o), 64'd3);
    flush_i     = 1'b1;
    cdb_ready_i = 1'b1;
    eu_data_i   = mk(15);
    step();
    flush_i     = 1'b0;
    eu_valid_i  = 1'b0;
    cdb_ready_i = 1'b0;
    check_eq("flush_count", 64'(count_o), 64'd0);
    check_eq("flush_valid", 64'(cdb_valid_o), 64'd0);
    check_eq("flush_ready", 64'(eu_ready_o), 64'd1);
    step();
    check_eq("flush_still_empty", 64'(cdb_valid_o), 64'd0);
    eu_valid_i = 1'b1;
    eu_data_i  = mk(1);
    eu_data_i.value = 64'h77;
    step();
    eu_data_i  = mk(2);
    check_eq("post_flush_idx", 64'(cdb_data_o.rob_idx), 64'd1);
    check_eq("post_flush_count", 64'(count_o), 64'd1);
    step();
    eu_valid_i = 1'b0;

    // Held head stable across stalls, then reset beats flush.
    check_eq("rstpri_pre_count", 64'(count_o), 64'd2);
    held = mk(1);
    held.value = 64'h77;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("stall_data_%0d", k), 64'(cdb_data_o.value), held.value);
      check_eq($sformatf("stall_idx_%0d", k), 64'(cdb_data_o.rob_idx), 64'(held.rob_idx));
      step();
    end
    rst_i       = 1'b1;
    flush_i     = 1'b1;
    cdb_ready_i = 1'b1;
    step();
    rst_i       = 1'b0;
    flush_i     = 1'b0;
    cdb_ready_i = 1'b0;
    check_eq("rstpri_count", 64'(count_o), 64'd0);
    check_eq("rstpri_ready", 64'(eu_ready_o), 64'd1);
    check_eq("rstpri_valid", 64'(cdb_valid_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
